// File: rtl/bsg_skid_buffer_pkg.sv
// rtl/bsg_skid_buffer_pkg.sv - shared state encoding and default widths for the skid buffer
package bsg_skid_buffer_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_e;

    localparam int WIDTH_DEFAULT           = 16;
    localparam int STALL_CNT_WIDTH_DEFAULT = 16;

endpackage

// File: rtl/bsg_dff_reset_en.sv
// rtl/bsg_dff_reset_en.sv - width-parameterized register, sync active-low reset, load enable
module bsg_dff_reset_en #(
    parameter int width_p = 16
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               en_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] data_o
);

    logic [width_p-1:0] data_q;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            data_q <= '0;
        end else if (en_i) begin
            data_q <= data_i;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/bsg_skid_buffer_reset.sv
// rtl/bsg_skid_buffer_reset.sv - two-entry skid buffer with registered handshakes
// Optional stall counter enabled by defining BSG_SKID_BUFFER_STALL_CNT_EN.
module bsg_skid_buffer_reset
    import bsg_skid_buffer_pkg::*;
#(
    parameter int width_p           = WIDTH_DEFAULT,
    parameter int stall_cnt_width_p = STALL_CNT_WIDTH_DEFAULT
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         v_i,
    input  logic [width_p-1:0]           data_i,
    output logic                         ready_o,
    output logic                         v_o,
    output logic [width_p-1:0]           data_o,
    input  logic                         ready_i
`ifdef BSG_SKID_BUFFER_STALL_CNT_EN
    ,
    output logic [stall_cnt_width_p-1:0] stall_cnt_o
`endif
);

    localparam logic [1:0] S_EMPTY = EMPTY;
    localparam logic [1:0] S_BUSY  = BUSY;
    localparam logic [1:0] S_FULL  = FULL;

    logic [1:0]         state_q;
    logic [1:0]         state_d;
    logic               accept;
    logic               pop;
    logic               main_en;
    logic               skid_en;
    logic               main_from_skid;
    logic [width_p-1:0] main_d;
    logic [width_p-1:0] skid_q;

    // Handshake outputs come only from state_q, so no v_i/ready_i feedthrough.
    assign v_o     = (state_q != S_EMPTY);
    assign ready_o = (state_q != S_FULL);
    assign accept  = v_i & ready_o;
    assign pop     = v_o & ready_i;

    always_comb begin
        state_d        = state_q;
        main_en        = 1'b0;
        skid_en        = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    main_en = 1'b1;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (accept && pop) begin
                    main_en = 1'b1;
                end else if (accept) begin
                    skid_en = 1'b1;
                    state_d = S_FULL;
                end else if (pop) begin
                    state_d = S_EMPTY;
                end
            end
            S_FULL: begin
                if (pop) begin
                    main_en        = 1'b1;
                    main_from_skid = 1'b1;
                    state_d        = S_BUSY;
                end
            end
            default: begin
                state_d = S_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    assign main_d = main_from_skid ? skid_q : data_i;

    bsg_dff_reset_en #(
        .width_p (width_p)
    ) main_reg (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .en_i      (main_en),
        .data_i    (main_d),
        .data_o    (data_o)
    );

    bsg_dff_reset_en #(
        .width_p (width_p)
    ) skid_reg (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .en_i      (skid_en),
        .data_i    (data_i),
        .data_o    (skid_q)
    );

`ifdef BSG_SKID_BUFFER_STALL_CNT_EN
    logic [stall_cnt_width_p-1:0] stall_cnt_q;
    logic [stall_cnt_width_p-1:0] stall_cnt_d;

    // Saturates at all-ones so a long stall never reads back as a short one.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (v_o && !ready_i && (stall_cnt_q != {stall_cnt_width_p{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    logic [stall_cnt_width_p-1:0] unused_stall_cnt_width;
    assign unused_stall_cnt_width = '0;
`endif

endmodule

// File: tb/tb_bsg_skid_buffer_reset.sv
// tb/tb_bsg_skid_buffer_reset.sv - scoreboard bench for bsg_skid_buffer_reset
module tb_bsg_skid_buffer_reset;

    localparam int W = 16;
`ifdef BSG_SKID_BUFFER_STALL_CNT_EN
    localparam int SW = 4;
`else
    localparam int SW = 16;
`endif

    logic          clk = 1'b0;
    logic          reset_n_i = 1'b0;
    logic          v_i = 1'b0;
    logic [W-1:0]  data_i = '0;
    logic          ready_i = 1'b0;
    logic          ready_o;
    logic          v_o;
    logic [W-1:0]  data_o;
`ifdef BSG_SKID_BUFFER_STALL_CNT_EN
    logic [SW-1:0] stall_cnt_o;
`endif

    always #5 clk = ~clk;

    bsg_skid_buffer_reset #(
        .width_p           (W),
        .stall_cnt_width_p (SW)
    ) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n_i),
        .v_i       (v_i),
        .data_i    (data_i),
        .ready_o   (ready_o),
        .v_o       (v_o),
        .data_o    (data_o),
        .ready_i   (ready_i)
`ifdef BSG_SKID_BUFFER_STALL_CNT_EN
        ,
        .stall_cnt_o (stall_cnt_o)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a FIFO of capacity two; occupancy decides the handshakes.
    logic [W-1:0] sb[$];
    int           occ = 0;
    bit           started = 0;
    bit           zero_exp = 0;
    int           exp_stall = 0;

    always @(posedge clk) begin
        if (!reset_n_i) begin
            occ       = 0;
            sb.delete();
            zero_exp  = 1;
            started   = 1;
            exp_stall = 0;
        end else if (started) begin
            bit acc;
            bit pp;
            acc = v_i && (occ < 2);
            pp  = (occ > 0) && ready_i;
            if ((occ > 0) && !ready_i && (exp_stall < (1 << SW) - 1))
                exp_stall = exp_stall + 1;
            occ = occ - int'(pp) + int'(acc);
            if (acc) begin
                sb.push_back(data_i);
                zero_exp = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("v_o", 32'(v_o), 32'(occ > 0));
            check("ready_o", 32'(ready_o), 32'(occ < 2));
            if (occ > 0) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'(sb.size()), 32'(occ));
                end else begin
                    check("data_o", 32'(data_o), 32'(sb[0]));
                    if (ready_i) void'(sb.pop_front());
                end
            end else if (zero_exp) begin
                check("data_o_reset", 32'(data_o), 32'h0);
            end
`ifdef BSG_SKID_BUFFER_STALL_CNT_EN
            check("stall_cnt_o", 32'(stall_cnt_o), 32'(exp_stall));
`endif
        end
    end

    task automatic cyc(input logic v, input logic [W-1:0] d, input logic r);
        v_i     = v;
        data_i  = d;
        ready_i = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n_i = 1'b0;
        cyc(1'b0, '0, 1'b0);
        cyc(1'b0, '0, 1'b0);
        reset_n_i = 1'b1;
    endtask

    initial begin
        do_reset();
        cyc(1'b0, '0, 1'b0);
        check("idle_v_o", 32'(v_o), 32'h0);
        check("idle_ready_o", 32'(ready_o), 32'h1);
        check("idle_data_o", 32'(data_o), 32'h0);

        for (int i = 1; i <= 16; i++) begin
            cyc(1'b1, W'(i), 1'b1);
            check("stream_data", 32'(data_o), 32'(i));
            check("stream_v_o", 32'(v_o), 32'h1);
        end
        cyc(1'b0, '0, 1'b1);

        cyc(1'b1, 16'hAAAA, 1'b0);
        cyc(1'b1, 16'h5555, 1'b0);
        check("bp_ready_o", 32'(ready_o), 32'h0);
        check("bp_data_hold", 32'(data_o), 32'hAAAA);
        cyc(1'b1, 16'hFFFF, 1'b0);
        cyc(1'b1, 16'hFFFF, 1'b0);
        check("bp_still_hold", 32'(data_o), 32'hAAAA);
        cyc(1'b0, '0, 1'b1);
        check("bp_second", 32'(data_o), 32'h5555);
        cyc(1'b0, '0, 1'b1);
        check("bp_drained", 32'(v_o), 32'h0);

        cyc(1'b1, 16'h1234, 1'b0);
        check("sim_busy", 32'(data_o), 32'h1234);
        cyc(1'b1, 16'h4321, 1'b1);
        check("sim_data", 32'(data_o), 32'h4321);
        check("sim_v_o", 32'(v_o), 32'h1);
        check("sim_ready_o", 32'(ready_o), 32'h1);
        cyc(1'b0, '0, 1'b1);

        cyc(1'b1, 16'hBEEF, 1'b0);
        cyc(1'b1, 16'hCAFE, 1'b0);
        check("full_ready_o", 32'(ready_o), 32'h0);
        reset_n_i = 1'b0;
        cyc(1'b1, 16'h9999, 1'b1);
        reset_n_i = 1'b1;
        check("midrst_v_o", 32'(v_o), 32'h0);
        check("midrst_ready_o", 32'(ready_o), 32'h1);
        check("midrst_data_o", 32'(data_o), 32'h0);
        cyc(1'b0, '0, 1'b0);

`ifdef BSG_SKID_BUFFER_STALL_CNT_EN
        cyc(1'b1, 16'h7777, 1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b0, '0, 1'b0);
        check("stall_sat", 32'(stall_cnt_o), 32'd15);
        cyc(1'b0, '0, 1'b0);
        check("stall_hold", 32'(stall_cnt_o), 32'd15);
        do_reset();
        check("stall_reset", 32'(stall_cnt_o), 32'd0);
`endif

        for (int i = 0; i < 3000; i++) begin
            reset_n_i = ($urandom_range(0, 199) != 0);
            cyc(($urandom_range(0, 3) != 0), W'($urandom), ($urandom_range(0, 2) != 0));
        end
        reset_n_i = 1'b1;
        for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1);
        check("final_empty", 32'(v_o), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bsg_skid_buffer_reset.md
BSG_SKID_BUFFER_RESET -- requirements
Module: bsg_skid_buffer_reset

Interface
REQ-001 SHALL have parameter width_p, default 16: payload width in bits.
REQ-002 SHALL have parameter stall_cnt_width_p, default 16: stall counter width; used only when BSG_SKID_BUFFER_STALL_CNT_EN is defined.
REQ-003 SHALL have port clk_i, input, 1: the single clock; all state updates on posedge.
REQ-004 SHALL have port reset_n_i, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port v_i, input, 1: upstream data valid.
REQ-006 SHALL have port data_i, input, width_p: upstream payload.
REQ-007 SHALL have port ready_o, output, 1: block can accept a word this cycle.
REQ-008 SHALL have port v_o, output, 1: data_o holds a valid word.
REQ-009 SHALL have port data_o, output, width_p: head payload, driven directly from a register.
REQ-010 SHALL have port ready_i, input, 1: downstream accepts the head word this cycle.
REQ-011 SHALL have port stall_cnt_o, output, stall_cnt_width_p: stall cycle count; present only when the macro is defined.

Function
REQ-012 SHALL hold up to two words: a main register driving data_o and a skid register.
REQ-013 SHALL implement states EMPTY (0 words), BUSY (main full), FULL (main and skid full).
REQ-014 SHALL drive v_o = (state != EMPTY) and ready_o = (state != FULL), both decoded from registered state only, with no combinational path from v_i or ready_i.
REQ-015 SHALL define accept as v_i & ready_o and pop as v_o & ready_i; v_i is ignored while ready_o=0.
REQ-016 In EMPTY, accept SHALL load main and go to BUSY; otherwise it SHALL stay EMPTY.
REQ-017 In BUSY:
- accept & pop SHALL load main with data_i and stay BUSY.
- accept & !pop SHALL load skid and go to FULL.
- pop & !accept SHALL go to EMPTY.
- with neither, it SHALL hold.
REQ-018 In FULL, pop SHALL copy skid into main and go to BUSY; otherwise it SHALL hold.
REQ-019 SHALL have a latency of 1 cycle: a word accepted at edge N appears on data_o with v_o=1 after edge N.
REQ-020 SHALL preserve order, never drop a word, and never duplicate a word.
REQ-021 SHALL sustain 1 word/cycle throughput while ready_i stays high.

Reset
REQ-022 When reset_n_i=0 at a posedge, the block SHALL enter EMPTY and clear main, skid and any counter to 0.
REQ-023 After reset, outputs SHALL be v_o=0, ready_o=1, data_o=0 and stall_cnt_o=0.
REQ-024 Reset mid-operation SHALL discard buffered words; reset SHALL have priority over accept and pop in the same cycle.

Configuration
REQ-025 Macro BSG_SKID_BUFFER_STALL_CNT_EN:
- When defined, the block SHALL count cycles with v_o=1 & ready_i=0 into stall_cnt_o.
- The count SHALL saturate at all-ones and SHALL not wrap.
REQ-026 When BSG_SKID_BUFFER_STALL_CNT_EN is undefined, stall_cnt_o and its logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-027 Package bsg_skid_buffer_pkg SHALL hold:
- the state enum (EMPTY, BUSY, FULL), 2 bits;
- default width constants for width_p and stall_cnt_width_p.
REQ-028 Both data registers SHALL use one sub-module, bsg_dff_reset_en: a width-parameterized register with synchronous active-low reset and load enable.
REQ-029 The state machine and counter SHALL reside in the top module.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- Reset, then idle: v_o=0, ready_o=1, data_o=0.
- Streaming: ready_i=1, send 0x0001..0x0010 on consecutive cycles; each word appears one cycle later, in order, no bubbles.
- Backpressure: ready_i=0, send 0xAAAA then 0x5555; ready_o drops to 0 after the second word and data_o stays 0xAAAA. Raise ready_i: outputs 0xAAAA then 0x5555. v_i=1 with 0xFFFF while ready_o=0 is never output.
- Simultaneous events: in BUSY holding 0x1234, v_i=1 with 0x4321 and ready_i=1; next cycle data_o=0x4321 and state stays BUSY.
- Reset mid-operation: in FULL, pulse reset_n_i=0 for one cycle alongside v_i=1 and ready_i=1; next cycle v_o=0, ready_o=1, data_o=0.
- Macro defined, stall_cnt_width_p=4: hold v_o=1 with ready_i=0 for 20 cycles; stall_cnt_o=15 and stays 15.
